// File: rtl/qs_pkg.sv
// -----------------------------------------------------------------------------
// qs_pkg
// Shared definitions for the quadrature input decoder:
//   - phase encoding constants for the filtered {A,B} pair
//   - INIT/RUN state enumeration of the decoder state machine
//   - step classification type and helper functions used by the decoder
// -----------------------------------------------------------------------------
package qs_pkg;

  // Filtered channel pair, bit 1 = A, bit 0 = B.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Width of the per-channel filter counter; covers FILTER_LEN up to 255.
  localparam int FILT_CNT_W = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dec_state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DOWN = 2'b10,
    STEP_ERR  = 2'b11
  } step_t;

  // Successor of a phase in the forward direction 00->10->11->01->00.
  function automatic logic [1:0] ph_fwd(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // Classify the move from prev to cur. A reverse step is simply a forward
  // step seen from the other side; anything else that changed is a
  // double-bit change and therefore illegal.
  function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    if (cur == prev) begin
      s = STEP_NONE;
    end else if (cur == ph_fwd(prev)) begin
      s = STEP_UP;
    end else if (prev == ph_fwd(cur)) begin
      s = STEP_DOWN;
    end else begin
      s = STEP_ERR;
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// -----------------------------------------------------------------------------
// quad_glitch_filter
// One encoder channel: 2-flop synchronizer followed by a persistence filter.
// The filtered value follows the synchronized value only after they have
// differed for FILTER_LEN consecutive clocks; any matching clock restarts
// the count, so shorter pulses never reach the output.
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   raw       in   asynchronous channel input
//   load      in   force filtered value to the synchronizer output now
//   sync      out  synchronizer output (second flop)
//   filtered  out  glitch-filtered channel value
// -----------------------------------------------------------------------------
module quad_glitch_filter
  import qs_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  output logic sync,
  output logic filtered
);

  logic                  sync1_reg;
  logic                  sync2_reg;
  logic                  filt_reg;
  logic                  filt_next;
  logic [FILT_CNT_W-1:0] cnt_reg;
  logic [FILT_CNT_W-1:0] cnt_next;

  // The counter holds the number of mismatching clocks already seen; the
  // FILTER_LEN-th mismatching clock is the one that updates the output.
  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);

  always_comb begin
    filt_next = filt_reg;
    cnt_next  = '0;
    if (load) begin
      filt_next = sync2_reg;
    end else if (sync2_reg != filt_reg) begin
      if (cnt_reg == CNT_LAST) begin
        filt_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      filt_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      filt_reg  <= filt_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign sync     = sync2_reg;
  assign filtered = filt_reg;

endmodule

// File: rtl/quad_input_decoder.sv
// -----------------------------------------------------------------------------
// quad_input_decoder
// Quadrature encoder front end: per-channel synchronizer + glitch filter,
// then a step decoder producing one-clock up/down/err strobes and a
// saturating error counter. After reset an INIT phase lets the synchronizers
// settle and adopts whatever position the encoder sits at, so power-up never
// produces a spurious step.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   quadA      in   encoder channel A (asynchronous)
//   quadB      in   encoder channel B (asynchronous)
//   up         out  one-clock strobe per forward step
//   down       out  one-clock strobe per reverse step
//   err        out  one-clock strobe per illegal (double-bit) transition
//   err_count  out  saturating count of err strobes since reset
//   phase      out  current filtered {A,B}
//
// up and down come straight from flops so they can drive the enable inputs
// of a downstream quad_counter without any further gating.
// -----------------------------------------------------------------------------
module quad_input_decoder
  import qs_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int ERR_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                quadA,
  input  logic                quadB,
  output logic                up,
  output logic                down,
  output logic                err,
  output logic [ERR_BITS-1:0] err_count,
  output logic [1:0]          phase
);

  // Reject out-of-range filter lengths at elaboration time.
  generate
    if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_len
      $error("quad_input_decoder: FILTER_LEN must be in 1..255");
    end
  endgenerate

  // INIT covers FILTER_LEN+2 clocks: count 0 .. FILTER_LEN+1.
  localparam int INIT_W = $clog2(FILTER_LEN + 3);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(FILTER_LEN + 1);
  localparam logic [ERR_BITS-1:0] ERR_MAX = {ERR_BITS{1'b1}};

  // ---------------------------------------------------------------------------
  // Channel filters (bit 1 = A, bit 0 = B)
  // ---------------------------------------------------------------------------
  logic [1:0] raw;
  logic [1:0] sync;
  logic [1:0] filt;
  logic       init_load;

  assign raw = {quadA, quadB};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      quad_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
      ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (raw[gi]),
        .load     (init_load),
        .sync     (sync[gi]),
        .filtered (filt[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // INIT/RUN state machine
  // ---------------------------------------------------------------------------
  dec_state_t        state_reg;
  dec_state_t        state_next;
  logic [INIT_W-1:0] init_cnt_reg;
  logic [INIT_W-1:0] init_cnt_next;
  logic              run_en;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (init_cnt_reg == INIT_LAST) begin
          state_next    = ST_RUN;
          init_cnt_next = '0;
        end else begin
          init_cnt_next = init_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next    = ST_INIT;
        init_cnt_next = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    init_load = 1'b0;
    run_en    = 1'b0;
    case (state_reg)
      ST_INIT: init_load = (init_cnt_reg == INIT_LAST);
      ST_RUN:  run_en    = 1'b1;
      default: begin
        init_load = 1'b0;
        run_en    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step decoder and error counter
  // ---------------------------------------------------------------------------
  logic [1:0]          prev_reg;
  logic [1:0]          prev_next;
  step_t               step;
  logic                up_reg;
  logic                down_reg;
  logic                err_reg;
  logic [ERR_BITS-1:0] err_count_reg;
  logic [ERR_BITS-1:0] err_count_next;

  assign step = classify(prev_reg, filt);

  // prev tracks the filtered value in RUN even after an illegal step, so a
  // single double-bit glitch costs one err strobe rather than desynchronising
  // the decoder. On the last INIT clock it adopts the synchronizer outputs,
  // exactly as the filters do, so the first RUN compare sees no change.
  always_comb begin
    prev_next      = prev_reg;
    err_count_next = err_count_reg;
    if (init_load) begin
      prev_next = sync;
    end else if (run_en) begin
      prev_next = filt;
      if (step == STEP_ERR && err_count_reg != ERR_MAX) begin
        err_count_next = err_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_reg      <= PH_00;
      up_reg        <= 1'b0;
      down_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
    end else begin
      prev_reg      <= prev_next;
      up_reg        <= run_en && (step == STEP_UP);
      down_reg      <= run_en && (step == STEP_DOWN);
      err_reg       <= run_en && (step == STEP_ERR);
      err_count_reg <= err_count_next;
    end
  end

  assign up        = up_reg;
  assign down      = down_reg;
  assign err       = err_reg;
  assign err_count = err_count_reg;
  assign phase     = filt;

endmodule

// File: tb/tb_quad_input_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_input_decoder
// Directed stimulus for quad_input_decoder (FILTER_LEN=4, ERR_BITS=8).
// Each input change that should yield a strobe pushes {kind, cycle} into a
// scoreboard queue; a monitor samples on the falling edge and pops an entry
// for every strobe it sees.
// -----------------------------------------------------------------------------
module tb_quad_input_decoder;

  localparam int FL  = 4;
  localparam int EB  = 8;
  localparam int LAT = FL + 3;

  localparam int K_NONE = 0;
  localparam int K_UP   = 1;
  localparam int K_DN   = 2;
  localparam int K_ERR  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          quad_a = 1'b0;
  logic          quad_b = 1'b0;
  logic          up;
  logic          down;
  logic          err;
  logic [EB-1:0] err_count;
  logic [1:0]    phase;

  quad_input_decoder #(
    .FILTER_LEN (FL),
    .ERR_BITS   (EB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .quadA     (quad_a),
    .quadB     (quad_b),
    .up        (up),
    .down      (down),
    .err       (err),
    .err_count (err_count),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input int kind);
    exp_t e;
    quad_a = a;
    quad_b = b;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.at   = cyc + LAT;
      sb.push_back(e);
    end
    $display("drive cyc=%0d AB=%b%b expect_kind=%0d", cyc, a, b, kind);
  endtask

  initial begin
    fork
      begin : monitor
        int   k;
        int   n;
        exp_t e;
        forever begin
          @(negedge clk);
          n = int'(up) + int'(down) + int'(err);
          if (n > 0) begin
            k = up ? K_UP : (down ? K_DN : K_ERR);
            if (n > 1) chk("strobe_exclusive", n, 1);
            if (sb.size() == 0) begin
              chk("unexpected_strobe", k, K_NONE);
            end else begin
              e = sb.pop_front();
              chk("strobe_kind", k, e.kind);
              chk("strobe_cycle", cyc, e.at);
              $display("strobe cyc=%0d kind=%0d err_count=%0d", cyc, k, err_count);
            end
          end
        end
      end
    join_none

    // Power-up with encoder parked at 11: no strobe, phase adopts 11.
    rst_n = 1'b0;
    quad_a = 1'b1;
    quad_b = 1'b1;
    clks(3);
    chk("reset_phase", int'(phase), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_strobes", int'(up) + int'(down) + int'(err), 0);
    rst_n = 1'b1;
    clks(FL + 2);
    chk("init_phase_11", int'(phase), 3);
    clks(20);
    chk("init_err_count", int'(err_count), 0);

    // Re-reset at 00 for the counting tests.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, K_NONE);
    clks(2);
    rst_n = 1'b1;
    clks(FL + 2 + 10);
    chk("idle_phase_00", int'(phase), 0);

    // Forward 4 steps, 20 clocks apart.
    drive(1'b1, 1'b0, K_UP); clks(20);
    drive(1'b1, 1'b1, K_UP); clks(20);
    drive(1'b0, 1'b1, K_UP); clks(20);
    drive(1'b0, 1'b0, K_UP); clks(20);
    chk("fwd_phase", int'(phase), 0);

    // Reverse 8 steps.
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 1'b1, K_DN); clks(20);
      drive(1'b1, 1'b1, K_DN); clks(20);
      drive(1'b1, 1'b0, K_DN); clks(20);
      drive(1'b0, 1'b0, K_DN); clks(20);
    end
    chk("rev_phase", int'(phase), 0);

    // 3-clock glitch on A is swallowed.
    drive(1'b1, 1'b0, K_NONE); clks(FL - 1);
    drive(1'b0, 1'b0, K_NONE); clks(20);
    chk("glitch_phase", int'(phase), 0);

    // 4-clock pulse is resolved: up then down.
    drive(1'b1, 1'b0, K_UP); clks(FL);
    drive(1'b0, 1'b0, K_DN); clks(20);
    chk("pulse_phase", int'(phase), 0);

    // Double-bit change: err strobe and counter.
    drive(1'b1, 1'b1, K_ERR); clks(LAT + 1);
    chk("err_count_1", int'(err_count), 1);
    for (int i = 1; i < 300; i++) begin
      drive((i % 2) == 0, (i % 2) == 0, K_ERR);
      clks(6);
    end
    clks(10);
    chk("err_count_sat", int'(err_count), 255);
    chk("err_phase", int'(phase), 0);

    // Reset two clocks after an A edge: that edge never strobes.
    drive(1'b1, 1'b0, K_NONE);
    clks(2);
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    chk("midstep_err_count", int'(err_count), 0);
    clks(FL + 2);
    chk("midstep_phase_10", int'(phase), 2);
    clks(10);
    drive(1'b1, 1'b1, K_UP); clks(20);
    drive(1'b0, 1'b1, K_UP); clks(20);
    chk("resume_phase_01", int'(phase), 1);

    clks(20);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/quad_input_decoder.md
QUAD_INPUT_DECODER -- requirements
Module: quad_input_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive clocks a synchronized input must differ from its filtered value before the filtered value follows; legal range 1..255.
REQ-002 Parameter ERR_BITS, default 8: width of err_count.
REQ-003 clk  input  1  system clock (internal oscillator domain, 53.2 MHz).
REQ-004 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 quadA  input  1  encoder channel A, asynchronous to clk.
REQ-006 quadB  input  1  encoder channel B, asynchronous to clk.
REQ-007 up  output  1  one-clock strobe per forward quadrature step.
REQ-008 down  output  1  one-clock strobe per reverse quadrature step.
REQ-009 err  output  1  one-clock strobe per illegal transition (both channels changed in one step).
REQ-010 err_count  output  ERR_BITS  saturating count of err strobes since reset.
REQ-011 phase  output  2  current filtered state {A,B}.

Function
REQ-012 Each channel passes through a 2-flop synchronizer, then a glitch filter.
REQ-013 Filter: per-channel counter increments while sync value != filtered value, clears to 0 on any cycle they match; when the counter reaches FILTER_LEN, filtered value takes the sync value and counter clears.
REQ-014 Pulses shorter than FILTER_LEN clocks (post-synchronizer) produce no filtered change.
REQ-015 Decoder compares filtered {A,B} with registered previous value prev every clock; prev is loaded with the filtered value every clock in RUN.
REQ-016 Forward sequence 00->10->11->01->00 asserts up; reverse 00->01->11->10->00 asserts down.
REQ-017 Unchanged state: up, down, err all 0.
REQ-018 Both bits changed (00<->11, 10<->01): err=1, up=down=0; prev still follows the new value.
REQ-019 up, down, err are registered, mutually exclusive, and high for exactly one clock.
REQ-020 Latency: a clean input transition stable from clock edge k produces its strobe high in the cycle following edge k+FILTER_LEN+3.
REQ-021 Minimum resolvable step spacing is FILTER_LEN+1 clocks; faster edges are filtered, never miscounted as the opposite direction.
REQ-022 err_count increments by 1 per err strobe and saturates at 2^ERR_BITS-1 (no wrap).
REQ-023 State machine INIT/RUN: INIT lasts FILTER_LEN+2 clocks after reset release; at the final INIT clock, filtered values and prev load directly from the synchronizer outputs; then RUN.
REQ-024 In INIT, up, down and err are 0 regardless of inputs, so an arbitrary encoder position at power-up produces no strobe.
REQ-025 phase reflects the filtered values in both states.

Reset
REQ-026 While rst_n=0 at a clock edge: synchronizers, filtered values, prev, filter counters = 0; up=down=err=0; err_count=0; phase=00; state=INIT.
REQ-027 Reset asserted mid-step discards any partially filtered edge; no strobe is emitted for it after release.

Structure
REQ-028 Shared package qs_pkg holds the phase encoding constants (PH_00, PH_10, PH_11, PH_01) and the INIT/RUN state enumeration.
REQ-029 One sub-module quad_glitch_filter (synchronizer + filter counter, parameter FILTER_LEN) is instantiated once per channel; decoder, state machine and err_count stay in quad_input_decoder.
REQ-030 The up/down outputs connect directly to quad_counter enable inputs; no other logic sits between them.

Verification (FILTER_LEN=4, ERR_BITS=8)
REQ-031 Reset with A=1,B=1 held, release -> no strobes; phase=11 after INIT (6 clocks); err_count=0.
REQ-032 Forward 4 steps {A,B} 00->10->11->01->00, 20 clocks per step -> exactly 4 up strobes, each 7 clocks after its edge, 0 down, 0 err.
REQ-033 Reverse 8 steps at 20 clocks/step -> 8 down strobes, no up.
REQ-034 3-clock glitch on A at phase 00 -> no strobe; phase stays 00; 4-clock pulse -> up then down.
REQ-035 A and B toggled same clock 00->11 -> err=1 for one clock, err_count=1; repeat 300 times -> err_count=255.
REQ-036 rst_n low for 1 clock 2 clocks after an A edge -> no strobe for that edge; normal counting resumes after INIT.
